// File: rtl/seq_add_sub.sv
// seq_add_sub: chunk-serial adder/subtractor.
// Operands are captured on an in_valid handshake. CHUNK bits are added per clock
// from the LSB upward, and the result is presented with a valid/ready handshake.
// WIDTH must be an integer multiple of CHUNK.
module seq_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  sum_chunk;
    logic [CHUNK:0]    rip;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Ripple a CHUNK-bit full adder over the currently selected slice of A and effective B.
    always_comb begin
        a_chunk   = a_reg[int'(idx)*CHUNK +: CHUNK];
        b_chunk   = b_reg[int'(idx)*CHUNK +: CHUNK];
        sum_chunk = '0;
        rip       = '0;
        rip[0]    = carry;
        for (int i = 0; i < CHUNK; i++) begin
            sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ rip[i];
            rip[i+1]     = (a_chunk[i] & b_chunk[i]) | (rip[i] & (a_chunk[i] ^ b_chunk[i]));
        end
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: accept in IDLE, walk the chunks in BUSY, hold in DONE until taken.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = BUSY;
            BUSY: if (idx == LAST_IDX) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture operands (subtract folds into ~b plus a carry-in of 1), then fill s one chunk per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                BUSY: begin
                    s[int'(idx)*CHUNK +: CHUNK] <= sum_chunk;
                    carry <= rip[CHUNK];
                    if (idx == LAST_IDX) begin
                        cout <= rip[CHUNK];
                        ovf  <= rip[CHUNK] ^ rip[CHUNK-1];
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
